// File: rtl/conv2d_frame_sequencer.sv
// Frame sequencer for a 3x3 conv engine: streams a frame from the input buffer, flushes the
// line buffers with zeros, and collects results into the output buffer. Optional DRAIN watchdog: CONV_SEQ_TIMEOUT_EN.
module conv2d_frame_sequencer #(
  parameter int DATA_WIDTH    = 32,
  parameter int IMG_WIDTH     = 56,
  parameter int IMG_HEIGHT    = 56,
  parameter int ADDR_WIDTH    = 12,
  parameter int DRAIN_TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  pause,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  conv_valid_in,
  output logic [DATA_WIDTH-1:0] conv_data_in,
  input  logic                  conv_valid_out,
  input  logic [DATA_WIDTH-1:0] conv_data_out,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout_err
);

  localparam int TOTAL = IMG_WIDTH * IMG_HEIGHT;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(TOTAL - 1);
  localparam int FLUSH_W = $clog2(IMG_WIDTH + 2);
  localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(IMG_WIDTH);

  typedef enum logic [2:0] {IDLE, FEED, FLUSH, DRAIN, FINISH} state_t;

  state_t state, state_nxt;
  logic [ADDR_WIDTH-1:0] rd_cnt, wr_cnt;
  logic [FLUSH_W-1:0]    flush_cnt;
  // Terminal flags stand in for "counter == TOTAL" so the counters never need an extra bit.
  logic rd_last_issued, wr_full;
  logic vld_p0;
  logic drain_tmo;
  logic accept;

  assign accept = (state == IDLE) && start;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (start) state_nxt = FEED;
      FEED:   if (rd_last_issued) state_nxt = FLUSH;
      FLUSH:  if (!pause && flush_cnt == FLUSH_LAST) state_nxt = DRAIN;
      DRAIN:  if (wr_full || drain_tmo) state_nxt = FINISH;
      FINISH: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rd_en         = (state == FEED) && !pause && !rd_last_issued;
    rd_addr       = rd_cnt;
    conv_valid_in = ((state == FEED) && vld_p0) || ((state == FLUSH) && !pause);
    conv_data_in  = ((state == FEED) && vld_p0) ? rd_data : '0;
    wr_en         = conv_valid_out && !wr_full;
    wr_addr       = wr_cnt;
    wr_data       = wr_en ? conv_data_out : '0;
    busy          = (state != IDLE);
    done          = (state == FINISH);
  end

  // Stage p0: read strobe delayed to line up with rd_data from the buffer.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p0         <= 1'b0;
      rd_cnt         <= '0;
      wr_cnt         <= '0;
      rd_last_issued <= 1'b0;
      wr_full        <= 1'b0;
      flush_cnt      <= '0;
    end else begin
      vld_p0 <= rd_en;
      if (accept) begin
        rd_cnt         <= '0;
        wr_cnt         <= '0;
        rd_last_issued <= 1'b0;
        wr_full        <= 1'b0;
        flush_cnt      <= '0;
      end else begin
        if (rd_en) begin
          if (rd_cnt == LAST_ADDR) rd_last_issued <= 1'b1;
          else                     rd_cnt <= rd_cnt + ADDR_WIDTH'(1);
        end
        if ((state == FLUSH) && !pause) flush_cnt <= flush_cnt + FLUSH_W'(1);
        if (wr_en) begin
          if (wr_cnt == LAST_ADDR) wr_full <= 1'b1;
          else                     wr_cnt <= wr_cnt + ADDR_WIDTH'(1);
        end
      end
    end
  end

`ifdef CONV_SEQ_TIMEOUT_EN
  localparam int TMO_W = $clog2(DRAIN_TIMEOUT + 1);
  logic [TMO_W-1:0] idle_cnt;
  logic             tmo_q;

  // Fires on the DRAIN_TIMEOUT-th consecutive idle cycle.
  assign drain_tmo   = (state == DRAIN) && !conv_valid_out && (idle_cnt == TMO_W'(DRAIN_TIMEOUT - 1));
  assign timeout_err = tmo_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      idle_cnt <= '0;
      tmo_q    <= 1'b0;
    end else begin
      if ((state != DRAIN) || conv_valid_out) idle_cnt <= '0;
      else                                    idle_cnt <= idle_cnt + TMO_W'(1);
      if (accept)         tmo_q <= 1'b0;
      else if (drain_tmo) tmo_q <= 1'b1;
    end
  end
`else
  assign drain_tmo   = 1'b0;
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_conv2d_frame_sequencer.sv
// Directed bench for conv2d_frame_sequencer on a 4x4 frame with a fixed-latency engine model.
module tb_conv2d_frame_sequencer;
  localparam int DW = 32, IW = 4, IH = 4, AW = 4, TOT = 16, DT = 8, LAT = 3;
`ifdef CONV_SEQ_TIMEOUT_EN
  localparam int TMO_EN = 1;
`else
  localparam int TMO_EN = 0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1, start = 1'b0, pause = 1'b0;
  logic rd_en, conv_valid_in, conv_valid_out, wr_en, busy, done, timeout_err;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [DW-1:0] rd_data = '0, conv_data_in, conv_data_out, wr_data;

  conv2d_frame_sequencer #(.DATA_WIDTH(DW), .IMG_WIDTH(IW), .IMG_HEIGHT(IH), .ADDR_WIDTH(AW),
                           .DRAIN_TIMEOUT(DT)) dut (
    .clk(clk), .reset(reset), .start(start), .pause(pause),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .conv_valid_in(conv_valid_in), .conv_data_in(conv_data_in),
    .conv_valid_out(conv_valid_out), .conv_data_out(conv_data_out),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .timeout_err(timeout_err));

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] pix(input int i);
    return 32'hA000_0001 + 32'(i) * 32'h0000_0111;
  endfunction

  function automatic logic [DW-1:0] res(input logic [DW-1:0] d);
    return d ^ 32'h5A5A_0000;
  endfunction

  // Frame buffer: one-cycle read latency.
  always @(posedge clk) if (rd_en) rd_data <= pix(int'(rd_addr));

  // Engine: LAT-cycle pipe, emits at most eng_limit results per frame.
  logic [LAT-1:0] ev;
  logic [DW-1:0]  ed [LAT];
  int eng_cnt, eng_limit;
  assign conv_valid_out = ev[LAT-1] && (eng_cnt < eng_limit);
  assign conv_data_out  = res(ed[LAT-1]);
  always @(posedge clk) begin
    if (reset) ev <= '0;
    else       ev <= {ev[LAT-2:0], conv_valid_in};
    ed[0] <= conv_data_in;
    for (int i = 1; i < LAT; i++) ed[i] <= ed[i-1];
    if (reset || (start && !busy)) eng_cnt <= 0;
    else if (conv_valid_out)       eng_cnt <= eng_cnt + 1;
  end

  // Monitor
  int cyc, rd_n, rd_bad, pix_n, pix_bad, fl_n, wr_n, wr_bad, done_n, busy_after_bad;
  int stamp_a, stamp_b, pause_at_m;
  bit trig, chk_busy_next;
  always @(negedge clk) begin
    cyc++;
    if (chk_busy_next) begin
      if (busy) busy_after_bad++;
      chk_busy_next = 1'b0;
    end
    if (rd_en) begin
      if (int'(rd_addr) != rd_n) rd_bad++;
      if (pause_at_m >= 0 && pause_at_m < TOT && int'(rd_addr) == pause_at_m) begin
        trig = 1'b1;
        stamp_a = cyc;
      end
      if (pause_at_m >= 0 && int'(rd_addr) == pause_at_m + 1) stamp_b = cyc;
      rd_n++;
    end
    if (conv_valid_in) begin
      if (pix_n < TOT) begin
        if (conv_data_in != pix(pix_n)) pix_bad++;
      end else begin
        fl_n++;
        if (conv_data_in != '0) pix_bad++;
      end
      pix_n++;
      if (pix_n == TOT && pause_at_m == TOT) trig = 1'b1;
    end
    if (wr_en) begin
      if (int'(wr_addr) != wr_n || wr_data != res(pix(wr_n))) wr_bad++;
      wr_n++;
    end
    if (done) begin
      done_n++;
      chk_busy_next = 1'b1;
    end
  end

  int n_chk = 0, n_err = 0;
  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".rd_en"}, int'(rd_en), 0);
    check({tag, ".rd_addr"}, int'(rd_addr), 0);
    check({tag, ".conv_valid_in"}, int'(conv_valid_in), 0);
    check({tag, ".conv_data_in"}, int'(conv_data_in), 0);
    check({tag, ".wr_en"}, int'(wr_en), 0);
    check({tag, ".wr_addr"}, int'(wr_addr), 0);
    check({tag, ".wr_data"}, int'(wr_data), 0);
    check({tag, ".busy"}, int'(busy), 0);
    check({tag, ".done"}, int'(done), 0);
    check({tag, ".timeout_err"}, int'(timeout_err), 0);
  endtask

  task automatic clear_mon(input int p_at);
    rd_n = 0; rd_bad = 0; pix_n = 0; pix_bad = 0; fl_n = 0; wr_n = 0; wr_bad = 0;
    done_n = 0; busy_after_bad = 0; stamp_a = -1; stamp_b = -1; trig = 1'b0;
    chk_busy_next = 1'b0; pause_at_m = p_at;
  endtask

  typedef struct {
    int pause_at;    // rd address after which to pause; TOT = first flush cycle
    int pause_len;
    int emit;        // results the engine will produce
    int restart_at;  // cycle of a stray start pulse, -1 none
    int exp_writes;
    int exp_done;
    int exp_busy;    // busy at end of run
    int exp_tmo;
  } vec_t;

  task automatic run_frame(input vec_t v, input int idx);
    int n, pcnt, after_done;
    string t;
    t = $sformatf("v%0d", idx);
    eng_limit = v.emit;
    @(posedge clk); #1;
    clear_mon(v.pause_at);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0; pcnt = 0; after_done = -1;
    while (n < 300 && after_done != 0) begin
      @(posedge clk); #1;
      n++;
      start = (n == v.restart_at);
      if (pcnt > 0) begin
        pause = 1'b1;
        pcnt--;
      end else if (trig) begin
        trig = 1'b0;
        pause = 1'b1;
        pcnt = v.pause_len - 1;
      end else pause = 1'b0;
      if (after_done > 0) after_done--;
      else if (after_done < 0 && done_n > 0) after_done = 2;
    end
    start = 1'b0;
    pause = 1'b0;
    check({t, ".rd_count"}, rd_n, TOT);
    check({t, ".rd_order_errs"}, rd_bad, 0);
    check({t, ".conv_in_count"}, pix_n, TOT + IW + 1);
    check({t, ".conv_in_data_errs"}, pix_bad, 0);
    check({t, ".flush_count"}, fl_n, IW + 1);
    check({t, ".wr_count"}, wr_n, v.exp_writes);
    check({t, ".wr_errs"}, wr_bad, 0);
    check({t, ".done_pulses"}, done_n, v.exp_done);
    check({t, ".busy_after_done"}, busy_after_bad, 0);
    check({t, ".busy_end"}, int'(busy), v.exp_busy);
    check({t, ".timeout_err"}, int'(timeout_err), v.exp_tmo);
    if (v.pause_at >= 0 && v.pause_at < TOT)
      check({t, ".pause_gap"}, stamp_b - stamp_a, v.pause_len + 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    vec_t vecs[7];
    int n;
    vecs[0] = '{-1, 0, 16, -1, 16, 1, 0, 0};
    vecs[1] = '{5, 3, 16, -1, 16, 1, 0, 0};
    vecs[2] = '{TOT, 2, 16, -1, 16, 1, 0, 0};
    vecs[3] = '{-1, 0, 16, 8, 16, 1, 0, 0};
    vecs[4] = '{-1, 0, 18, -1, 16, 1, 0, 0};
    vecs[5] = '{-1, 0, 12, -1, 12, TMO_EN, 1 - TMO_EN, TMO_EN};
    vecs[6] = '{-1, 0, 16, -1, 16, 1, 0, 0};
    eng_limit = 16;
    clear_mon(-1);

    // Reset together with start: reset wins.
    reset = 1'b1; start = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_idle("reset");
    start = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    check("idle_after_reset.busy", int'(busy), 0);

    // Reset mid-frame at read address 9.
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(rd_en && rd_addr == AW'(9)) && n < 50);
    check("midreset.reached_addr9", int'(rd_en && rd_addr == AW'(9)), 1);
    reset = 1'b1;
    @(posedge clk); #1;
    check_idle("midreset");
    reset = 1'b0;

    for (int i = 0; i < 7; i++) begin
      run_frame(vecs[i], i);
      if (busy) begin
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check($sformatf("v%0d.recover_busy", i), int'(busy), 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/conv2d_frame_sequencer.md
CONV2D_FRAME_SEQUENCER -- requirements
Module: conv2d_frame_sequencer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: pixel word width.
REQ-002 SHALL have parameter IMG_WIDTH, default 56: pixels per row.
REQ-003 SHALL have parameter IMG_HEIGHT, default 56: rows per frame.
REQ-004 SHALL have parameter ADDR_WIDTH, default 12: frame-buffer address width; must satisfy 2^ADDR_WIDTH >= IMG_WIDTH*IMG_HEIGHT (TOTAL).
REQ-005 SHALL have parameter DRAIN_TIMEOUT, default 64: maximum idle cycles allowed in DRAIN.
REQ-006 clk  input  1  single clock; all logic samples on its rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 start  input  1  one-cycle request to process one frame.
REQ-009 pause  input  1  level; freezes frame feed while high.
REQ-010 rd_en  output  1  input frame-buffer read strobe.
REQ-011 rd_addr  output  ADDR_WIDTH  input frame-buffer read address.
REQ-012 rd_data  input  DATA_WIDTH  frame-buffer read data, valid exactly 1 cycle after rd_en.
REQ-013 conv_valid_in  output  1  valid to the 3x3 conv engine.
REQ-014 conv_data_in  output  DATA_WIDTH  pixel to the conv engine.
REQ-015 conv_valid_out  input  1  result valid from the conv engine.
REQ-016 conv_data_out  input  DATA_WIDTH  result from the conv engine.
REQ-017 wr_en, wr_addr (ADDR_WIDTH), wr_data (DATA_WIDTH)  outputs  output frame-buffer write port.
REQ-018 busy  output  1  high from start acceptance until done.
REQ-019 done  output  1  one-cycle pulse at frame completion.
REQ-020 timeout_err  output  1  sticky; set when DRAIN times out.

Function
REQ-021 FSM states SHALL be IDLE, FEED, FLUSH, DRAIN, FINISH.
REQ-022 IDLE: start=1 -> FEED, read counter and write counter cleared, timeout_err cleared; start in any other state SHALL be ignored.
REQ-023 FEED: each cycle with pause=0 SHALL assert rd_en with rd_addr = read counter (0..TOTAL-1), then increment; pause=1 SHALL hold rd_en=0 and the counter.
REQ-024 conv_valid_in SHALL equal rd_en delayed one cycle in FEED, with conv_data_in = rd_data in that cycle; engine never sees an unfilled pixel.
REQ-025 After issuing address TOTAL-1, the FSM SHALL enter FLUSH once the last pixel is forwarded.
REQ-026 FLUSH: SHALL drive conv_valid_in=1, conv_data_in=0 for exactly IMG_WIDTH+1 non-paused cycles, pause freezing the flush counter and deasserting conv_valid_in, then enter DRAIN.
REQ-027 In every state, each cycle with conv_valid_out=1 and write counter < TOTAL SHALL produce wr_en=1, wr_addr = write counter, wr_data = conv_data_out in the same cycle, then increment; results beyond TOTAL SHALL be dropped.
REQ-028 DRAIN: conv_valid_in=0; when write counter reaches TOTAL -> FINISH.
REQ-029 FINISH: done=1 for one cycle, then IDLE; busy=1 in FEED, FLUSH, DRAIN, FINISH else 0.
REQ-030 Counters SHALL be ADDR_WIDTH bits and never wrap; terminal comparison uses TOTAL-1.
REQ-031 Write reaching TOTAL during FEED or FLUSH SHALL not shorten FEED/FLUSH; DRAIN then exits next cycle.

Reset
REQ-032 reset=1 SHALL, at the next clk edge, force IDLE from any state, counters 0, and rd_en, conv_valid_in, wr_en, busy, done, timeout_err = 0; conv_data_in, wr_data, rd_addr, wr_addr = 0.
REQ-033 reset SHALL take priority over start and conv_valid_out in the same cycle.

Configuration
REQ-034 With macro CONV_SEQ_TIMEOUT_EN defined, DRAIN SHALL count consecutive cycles with conv_valid_out=0; at DRAIN_TIMEOUT it SHALL set timeout_err=1 and go to FINISH (done still pulses); counter resets on any conv_valid_out.
REQ-035 Without CONV_SEQ_TIMEOUT_EN, DRAIN SHALL wait indefinitely and timeout_err SHALL be constant 0.

Verification (IMG_WIDTH=4, IMG_HEIGHT=4, TOTAL=16, model engine with fixed latency)
REQ-036 Nominal: start pulse -> rd_addr 0..15 on consecutive cycles, 16 conv_valid_in pixels then 5 zero-valued flush cycles, 16 writes to wr_addr 0..15, single done pulse, busy low next cycle.
REQ-037 Pause: pause=1 for 3 cycles after rd_addr 5 -> no rd_en for 3 cycles, feed resumes at address 6, pixel order and write addresses unchanged.
REQ-038 Start ignored: second start while busy -> no counter reset, exactly one done pulse.
REQ-039 Reset mid-frame: reset at rd_addr 9 -> next cycle all outputs 0, state IDLE; new start processes full frame from address 0.
REQ-040 Timeout (CONV_SEQ_TIMEOUT_EN defined, DRAIN_TIMEOUT=8): engine stops after 12 results -> done after 8 idle DRAIN cycles, timeout_err=1 until next start; without macro -> busy stays 1, no done.
REQ-041 Overflow: engine emits 18 results -> only wr_addr 0..15 written, extra 2 dropped, done pulses once.
